// File: rtl/ve_ctrl_seq_if.sv
// ve_ctrl_seq_if: bus bundle between the VE instruction sequencer and its
// environment (instruction source, EBuffer/GBuffer read ports, VE array).
//   instruction channel : instValid/instReady + inst* fields
//   buffer read ports   : eRdEn/eRdAddr, gRdEn/gRdAddr
//   array control       : eValid/eFirst/eLast/eOpCode/colBegin/colEnd/eImm/evWSync, eFinish
//   status              : busy, done
// modport master = sequencer side, modport slave = environment side.
interface ve_ctrl_seq_if #(
  parameter int unsigned EBufAddrW = 10,
  parameter int unsigned GBufAddrW = 8,
  parameter int unsigned ELTBIT    = 16
);
  logic                 instValid;
  logic                 instReady;
  logic [1:0]           instOpCode;
  logic [GBufAddrW-1:0] instColBegin;
  logic [GBufAddrW-1:0] instColEnd;
  logic [7:0]           instRowNum;
  logic [EBufAddrW-1:0] instEBase;
  logic [ELTBIT-1:0]    instImm;
  logic                 instEvSync;

  logic                 eRdEn;
  logic [EBufAddrW-1:0] eRdAddr;
  logic                 gRdEn;
  logic [GBufAddrW-1:0] gRdAddr;

  logic                 eValid;
  logic                 eFirst;
  logic                 eLast;
  logic [1:0]           eOpCode;
  logic [GBufAddrW-1:0] colBegin;
  logic [GBufAddrW-1:0] colEnd;
  logic [ELTBIT-1:0]    eImm;
  logic                 evWSync;
  logic                 eFinish;

  logic                 busy;
  logic                 done;

  modport master (
    input  instValid, instOpCode, instColBegin, instColEnd, instRowNum,
           instEBase, instImm, instEvSync, eFinish,
    output instReady, eRdEn, eRdAddr, gRdEn, gRdAddr,
           eValid, eFirst, eLast, eOpCode, colBegin, colEnd, eImm, evWSync,
           busy, done
  );

  modport slave (
    output instValid, instOpCode, instColBegin, instColEnd, instRowNum,
           instEBase, instImm, instEvSync, eFinish,
    input  instReady, eRdEn, eRdAddr, gRdEn, gRdAddr,
           eValid, eFirst, eLast, eOpCode, colBegin, colEnd, eImm, evWSync,
           busy, done
  );
endinterface

// File: rtl/ve_ctrl_seq.sv
// ve_ctrl_seq: VE array instruction sequencer.
// Accepts one element-op instruction, walks its column x row space issuing one
// EBuffer/GBuffer read per cycle, replays the beat strobes RDLAT cycles later
// to line up with the read data, then retires on the array's eFinish.
// Ports: clk, rst_n (async active-low), bus (ve_ctrl_seq_if.master).
module ve_ctrl_seq #(
  parameter int unsigned EBufAddrW = 10,
  parameter int unsigned GBufAddrW = 8,
  parameter int unsigned ELTBIT    = 16,
  parameter int unsigned RDLAT     = 1
) (
  input logic          clk,
  input logic          rst_n,
  ve_ctrl_seq_if.master bus
);

  localparam int unsigned RowW = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t               state, stateNext;
  logic [EBufAddrW-1:0] eAddr, eAddrNext;
  logic [GBufAddrW-1:0] colCnt, colCntNext;
  logic [RowW-1:0]      rowCnt, rowCntNext;
  logic [1:0]           opQ, opNext;
  logic [GBufAddrW-1:0] colBeginQ, colBeginNext;
  logic [GBufAddrW-1:0] colEndQ, colEndNext;
  logic [RowW-1:0]      rowNumQ, rowNumNext;
  logic [ELTBIT-1:0]    immQ, immNext;
  logic                 syncQ, syncNext;
  logic                 degenQ, degenNext;
  logic                 eRdEnQ, eRdEnNext;
  logic                 gRdEnQ, gRdEnNext;
  logic                 instReadyQ, instReadyNext;
  logic                 busyQ, busyNext;
  logic                 doneQ, doneNext;
  logic                 rowEnd;
  logic                 beatVld, beatFirst, beatLast;
  logic [RDLAT-1:0]     vldPipe, firstPipe, lastPipe;
  logic [RDLAT-1:0]     vldShift, firstShift, lastShift;

  // Strobe delay line: stage 0 is the beat issued last cycle, tail drives the array.
  if (RDLAT == 1) begin : gShift1
    assign vldShift   = beatVld;
    assign firstShift = beatFirst;
    assign lastShift  = beatLast;
  end else begin : gShiftN
    assign vldShift   = {vldPipe[RDLAT-2:0], beatVld};
    assign firstShift = {firstPipe[RDLAT-2:0], beatFirst};
    assign lastShift  = {lastPipe[RDLAT-2:0], beatLast};
  end

  // Next-state, counters and registered-output next values.
  always_comb begin
    stateNext    = state;
    eAddrNext    = eAddr;
    colCntNext   = colCnt;
    rowCntNext   = rowCnt;
    opNext       = opQ;
    colBeginNext = colBeginQ;
    colEndNext   = colEndQ;
    rowNumNext   = rowNumQ;
    immNext      = immQ;
    syncNext     = syncQ;
    degenNext    = degenQ;
    doneNext     = 1'b0;
    beatVld      = 1'b0;
    beatFirst    = 1'b0;
    beatLast     = 1'b0;
    rowEnd       = (rowCnt == rowNumQ - RowW'(1));

    case (state)
      IDLE: begin
        if (bus.instValid) begin
          opNext       = (bus.instOpCode == 2'd3) ? 2'd0 : bus.instOpCode;
          colBeginNext = bus.instColBegin;
          colEndNext   = bus.instColEnd;
          rowNumNext   = bus.instRowNum;
          immNext      = bus.instImm;
          syncNext     = bus.instEvSync;
          degenNext    = (bus.instRowNum == RowW'(0)) || (bus.instColEnd < bus.instColBegin);
          eAddrNext    = bus.instEBase;
          colCntNext   = bus.instColBegin;
          rowCntNext   = '0;
          stateNext    = degenNext ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        beatVld   = 1'b1;
        beatFirst = (rowCnt == '0) && (colCnt == colBeginQ);
        beatLast  = rowEnd;
        eAddrNext = eAddr + EBufAddrW'(1);
        if (rowEnd) begin
          rowCntNext = '0;
          colCntNext = colCnt + GBufAddrW'(1);
          // Explicit end compare: ColEnd may be the all-ones column.
          if (colCnt == colEndQ) stateNext = DRAIN;
        end else begin
          rowCntNext = rowCnt + RowW'(1);
        end
      end
      DRAIN: begin
        if (doneQ) begin
          stateNext = IDLE;
        end else if (!(|vldPipe) && (bus.eFinish || degenQ)) begin
          doneNext = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase

    eRdEnNext     = (stateNext == ISSUE);
    gRdEnNext     = (stateNext == ISSUE) && (opNext != 2'd0);
    instReadyNext = (stateNext == IDLE);
    busyNext      = (stateNext != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      eAddr      <= '0;
      colCnt     <= '0;
      rowCnt     <= '0;
      opQ        <= '0;
      colBeginQ  <= '0;
      colEndQ    <= '0;
      rowNumQ    <= '0;
      immQ       <= '0;
      syncQ      <= 1'b0;
      degenQ     <= 1'b0;
      eRdEnQ     <= 1'b0;
      gRdEnQ     <= 1'b0;
      instReadyQ <= 1'b1;
      busyQ      <= 1'b0;
      doneQ      <= 1'b0;
      vldPipe    <= '0;
      firstPipe  <= '0;
      lastPipe   <= '0;
    end else begin
      state      <= stateNext;
      eAddr      <= eAddrNext;
      colCnt     <= colCntNext;
      rowCnt     <= rowCntNext;
      opQ        <= opNext;
      colBeginQ  <= colBeginNext;
      colEndQ    <= colEndNext;
      rowNumQ    <= rowNumNext;
      immQ       <= immNext;
      syncQ      <= syncNext;
      degenQ     <= degenNext;
      eRdEnQ     <= eRdEnNext;
      gRdEnQ     <= gRdEnNext;
      instReadyQ <= instReadyNext;
      busyQ      <= busyNext;
      doneQ      <= doneNext;
      vldPipe    <= vldShift;
      firstPipe  <= firstShift;
      lastPipe   <= lastShift;
    end
  end

  assign bus.instReady = instReadyQ;
  assign bus.busy      = busyQ;
  assign bus.done      = doneQ;
  assign bus.eRdEn     = eRdEnQ;
  assign bus.eRdAddr   = eAddr;
  assign bus.gRdEn     = gRdEnQ;
  assign bus.gRdAddr   = colCnt;
  assign bus.eValid    = vldPipe[RDLAT-1];
  assign bus.eFirst    = firstPipe[RDLAT-1];
  assign bus.eLast     = lastPipe[RDLAT-1];
  assign bus.eOpCode   = opQ;
  assign bus.colBegin  = colBeginQ;
  assign bus.colEnd    = colEndQ;
  assign bus.eImm      = immQ;
  assign bus.evWSync   = syncQ;

endmodule

// File: tb/tb_ve_ctrl_seq.sv
// tb_ve_ctrl_seq: scoreboard bench for ve_ctrl_seq. Expected read beats and
// array strobes (with their cycle numbers) are queued when an instruction is
// driven and popped by a negedge monitor as the DUT produces them.
module tb_ve_ctrl_seq;

  localparam int unsigned EBufAddrW = 10;
  localparam int unsigned GBufAddrW = 8;
  localparam int unsigned ELTBIT    = 16;
  localparam int unsigned RDLAT     = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   nChecks = 0;
  int   nPass = 0;

  typedef struct {
    int          cyc;
    logic [9:0]  addr;
    logic        gEn;
    logic [7:0]  gAddr;
    logic        first;
    logic        last;
    logic [1:0]  op;
    logic [7:0]  cb;
    logic [7:0]  ce;
    logic [15:0] imm;
    logic        sync;
  } beat_t;

  beat_t rdQ[$];
  beat_t evQ[$];

  logic [1:0]  pOp;
  logic [7:0]  pCb, pCe, pRn;
  logic [9:0]  pBase;
  logic [15:0] pImm;
  logic        pSync;

  ve_ctrl_seq_if #(.EBufAddrW(EBufAddrW), .GBufAddrW(GBufAddrW), .ELTBIT(ELTBIT)) bus ();

  ve_ctrl_seq #(
    .EBufAddrW(EBufAddrW), .GBufAddrW(GBufAddrW), .ELTBIT(ELTBIT), .RDLAT(RDLAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic chkFields(input string pfx, input beat_t b);
    chk({pfx, "_op"},   32'(bus.eOpCode),  32'(b.op));
    chk({pfx, "_cb"},   32'(bus.colBegin), 32'(b.cb));
    chk({pfx, "_ce"},   32'(bus.colEnd),   32'(b.ce));
    chk({pfx, "_imm"},  32'(bus.eImm),     32'(b.imm));
    chk({pfx, "_sync"}, 32'(bus.evWSync),  32'(b.sync));
  endtask

  // Monitor: every read and every array beat must match the head of its queue.
  always @(negedge clk) begin : monitor
    beat_t b;
    if (rst_n) begin
      if (bus.gRdEn && !bus.eRdEn) chk("stray_grd", 1, 0);
      if (bus.eRdEn) begin
        if (rdQ.size() == 0) chk("stray_rd", 1, 0);
        else begin
          b = rdQ.pop_front();
          chk("rd_cycle", cyc, b.cyc);
          chk("rd_addr", 32'(bus.eRdAddr), 32'(b.addr));
          chk("g_en", 32'(bus.gRdEn), 32'(b.gEn));
          if (b.gEn) chk("g_addr", 32'(bus.gRdAddr), 32'(b.gAddr));
          chkFields("rd", b);
        end
      end
      if (bus.eValid) begin
        if (evQ.size() == 0) chk("stray_ev", 1, 0);
        else begin
          b = evQ.pop_front();
          chk("ev_cycle", cyc, b.cyc);
          chk("ev_first", 32'(bus.eFirst), 32'(b.first));
          chk("ev_last", 32'(bus.eLast), 32'(b.last));
          chkFields("ev", b);
        end
      end
    end
  end

  task automatic setInst(input logic [1:0] op, input logic [7:0] cb, input logic [7:0] ce,
                         input logic [7:0] rn, input logic [9:0] base, input logic [15:0] imm,
                         input logic sync);
    pOp = op; pCb = cb; pCe = ce; pRn = rn; pBase = base; pImm = imm; pSync = sync;
    bus.instValid    = 1'b1;
    bus.instOpCode   = op;
    bus.instColBegin = cb;
    bus.instColEnd   = ce;
    bus.instRowNum   = rn;
    bus.instEBase    = base;
    bus.instImm      = imm;
    bus.instEvSync   = sync;
  endtask

  // Queue the expected beats of the pending instruction, first read in cycle A.
  task automatic pushExp(input int A, output int B, output logic dg);
    beat_t b;
    int k;
    k = 0;
    dg = (pRn == 8'd0) || (pCe < pCb);
    if (!dg) begin
      for (int c = int'(pCb); c <= int'(pCe); c++) begin
        for (int r = 0; r < int'(pRn); r++) begin
          b.cyc   = A + k;
          b.addr  = 10'(int'(pBase) + k);
          b.gEn   = (pOp == 2'd1) || (pOp == 2'd2);
          b.gAddr = 8'(c);
          b.first = (k == 0);
          b.last  = (r == int'(pRn) - 1);
          b.op    = pOp;
          b.cb    = pCb;
          b.ce    = pCe;
          b.imm   = pImm;
          b.sync  = pSync;
          rdQ.push_back(b);
          b.cyc   = A + k + int'(RDLAT);
          evQ.push_back(b);
          k++;
        end
      end
    end
    B = k;
  endtask

  // Drive eFinish once the pipeline is empty, check the retire pulse timing.
  task automatic finishInst(input int A, input int B, input logic dg, input logic earlyFin);
    int   F, expDone;
    logic seen;
    F = A + B + int'(RDLAT);
    expDone = dg ? A + 1 : F + 1;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      if (!dg && cyc == F) bus.eFinish = 1'b1;
      else if (earlyFin && !dg && (cyc == A + 1 || cyc == A + B - 1 + int'(RDLAT))) bus.eFinish = 1'b1;
      else bus.eFinish = 1'b0;
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    bus.eFinish = 1'b0;
    chk("done_seen", 32'(seen), 1);
    if (seen) chk("done_cycle", cyc, expDone);
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 0);
    chk("ready_after", 32'(bus.instReady), 1);
    chk("busy_after", 32'(bus.busy), 0);
    chk("rd_drained", rdQ.size(), 0);
    chk("ev_drained", evQ.size(), 0);
  endtask

  task automatic runInst(input logic [1:0] op, input logic [7:0] cb, input logic [7:0] ce,
                         input logic [7:0] rn, input logic [9:0] base, input logic [15:0] imm,
                         input logic sync, input logic earlyFin);
    int A, B;
    logic dg;
    chk("ready_pre", 32'(bus.instReady), 1);
    setInst(op, cb, ce, rn, base, imm, sync);
    A = cyc + 1;
    pushExp(A, B, dg);
    @(negedge clk);
    bus.instValid = 1'b0;
    chk("busy_accept", 32'(bus.busy), 1);
    finishInst(A, B, dg, earlyFin);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int A, B, A2, B2;
    logic dg, dg2;
    bus.instValid = 1'b0; bus.instOpCode = '0; bus.instColBegin = '0; bus.instColEnd = '0;
    bus.instRowNum = '0; bus.instEBase = '0; bus.instImm = '0; bus.instEvSync = 1'b0;
    bus.eFinish = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.instReady), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rden", 32'(bus.eRdEn), 0);
    chk("rst_evalid", 32'(bus.eValid), 0);
    chk("rst_opcode", 32'(bus.eOpCode), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_imm", 32'(bus.eImm), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // MaxReduce and ExpProd over columns 2..3, two rows each
    runInst(2'd0, 8'd2, 8'd3, 8'd2, 10'h010, 16'h1234, 1'b0, 1'b0);
    runInst(2'd1, 8'd2, 8'd3, 8'd2, 10'h020, 16'hABCD, 1'b1, 1'b0);
    // EBuffer address wrap, then all-ones column with a single row
    runInst(2'd2, 8'd5, 8'd5, 8'd4, 10'h3FE, 16'h0042, 1'b0, 1'b0);
    runInst(2'd0, 8'hFF, 8'hFF, 8'd1, 10'h100, 16'h0007, 1'b1, 1'b0);
    // Degenerate: zero rows, then reversed column range
    runInst(2'd1, 8'd1, 8'd4, 8'd0, 10'h000, 16'h0001, 1'b0, 1'b0);
    runInst(2'd2, 8'd5, 8'd4, 8'd3, 10'h200, 16'h0002, 1'b1, 1'b0);
    // Early eFinish pulses must be ignored
    runInst(2'd1, 8'd0, 8'd1, 8'd4, 10'h040, 16'h5555, 1'b0, 1'b1);

    // instValid held through busy with the next instruction's fields
    chk("ready_hold_pre", 32'(bus.instReady), 1);
    setInst(2'd0, 8'd1, 8'd1, 8'd3, 10'h050, 16'h1111, 1'b0);
    A = cyc + 1;
    pushExp(A, B, dg);
    @(negedge clk);
    setInst(2'd2, 8'd7, 8'd8, 8'd2, 10'h060, 16'h2222, 1'b1);
    chk("ready_busy", 32'(bus.instReady), 0);
    finishInst(A, B, dg, 1'b0);
    A2 = cyc + 1;
    pushExp(A2, B2, dg2);
    @(negedge clk);
    bus.instValid = 1'b0;
    chk("busy_second", 32'(bus.busy), 1);
    finishInst(A2, B2, dg2, 1'b0);

    // Reset during beat 2 of 8
    chk("ready_rst_pre", 32'(bus.instReady), 1);
    setInst(2'd1, 8'd0, 8'd1, 8'd4, 10'h070, 16'h3333, 1'b1);
    A = cyc + 1;
    pushExp(A, B, dg);
    @(negedge clk);
    bus.instValid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rden", 32'(bus.eRdEn), 0);
    chk("arst_grden", 32'(bus.gRdEn), 0);
    chk("arst_evalid", 32'(bus.eValid), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_ready", 32'(bus.instReady), 1);
    chk("arst_addr", 32'(bus.eRdAddr), 0);
    rdQ.delete();
    evQ.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_ready", 32'(bus.instReady), 1);
    chk("post_rst_busy", 32'(bus.busy), 0);
    runInst(2'd1, 8'd3, 8'd3, 8'd2, 10'h080, 16'h4444, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/ve_ctrl_seq.md
# ve_ctrl_seq

Instruction sequencer for the vector-element (VE) array. It accepts one element-op instruction at a time (MaxReduce, ExpProd or MergeNorm) and walks the column/row iteration space. For each beat it issues EBuffer and GBuffer read requests. After the buffer read latency it drives the VE array control strobes (eValid/eFirst/eLast/eOpCode/colBegin/colEnd/eImm/evWSync) aligned with the returned read data. It then waits for the array's eFinish before retiring the instruction.

## Interface
- EBufAddrW, 10, EBuffer read address width
- GBufAddrW, 8, GBuffer address width (column index)
- ELTBIT, 16, element / immediate width
- RDLAT, 1, buffer read latency in cycles (1..4)

Ports:
- clk  in  1  clock (single clock domain)
- rst_n  in  1  asynchronous active-low reset
- instValid  in  1  instruction offered
- instReady  out  1  high only in IDLE
- instOpCode  in  2  0=MaxReduce, 1=ExpProd, 2=MergeNorm (3 treated as MaxReduce)
- instColBegin  in  GBufAddrW  first column
- instColEnd  in  GBufAddrW  last column (inclusive)
- instRowNum  in  8  vector reads per column
- instEBase  in  EBufAddrW  EBuffer start address
- instImm  in  ELTBIT  immediate (1/N for MergeNorm)
- instEvSync  in  1  EV write-sync request
- eRdEn  out  1  EBuffer read enable
- eRdAddr  out  EBufAddrW  EBuffer read address
- gRdEn  out  1  GBuffer read enable
- gRdAddr  out  GBufAddrW  GBuffer read address
- eValid, eFirst, eLast  out  1 each  array beat strobes
- eOpCode  out  2  latched opcode
- colBegin, colEnd  out  GBufAddrW  latched column range
- eImm  out  ELTBIT  latched immediate
- evWSync  out  1  latched instEvSync
- eFinish  in  1  array finished last write-back
- busy  out  1  state != IDLE
- done  out  1  one-cycle retire pulse

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: instReady=1. On instValid, latch all inst* fields, clear the counters and go to ISSUE.
- Degenerate instruction (instRowNum==0 or instColEnd<instColBegin): go directly to DRAIN with no beats. In DRAIN it retires without waiting for eFinish.
- ISSUE: one beat per cycle, no stalls.
  - eRdEn=1; eRdAddr = running counter starting at instEBase, +1 per beat, wraps modulo 2^EBufAddrW.
  - gRdEn=1 only for ExpProd/MergeNorm; gRdAddr = current column.
  - rowCnt counts 0..RowNum-1. On wrap it clears and colCnt increments.
  - The beat with colCnt==ColEnd and rowCnt==RowNum-1 is the last beat; the next state is DRAIN.
- Strobe pipeline: depth RDLAT shift register carrying {valid, first, last}.
  - first = first beat of the instruction.
  - last = rowCnt==RowNum-1 (end of each column).
  - Outputs eValid/eFirst/eLast come from the tail of the pipeline.
- eOpCode/colBegin/colEnd/eImm/evWSync are held stable from the accept edge until the next accept.
- DRAIN:
  - Waits for the pipeline to empty, then samples eFinish.
  - eFinish=1 → done=1 for one cycle, then return to IDLE.
  - eFinish in IDLE/ISSUE, or while the pipeline is non-empty, is ignored (no state change).
- Column counter uses GBufAddrW bits. ColEnd = 2^GBufAddrW−1 must terminate correctly: compare against ColEnd, never rely on overflow.

## Timing
- Reset values: state=IDLE, instReady=1, every other output 0, pipeline cleared. eOpCode=0 (MaxReduce).
- Accept at edge T → busy=1 and first read request in cycle T+1.
- Beat k (0-based) read is in cycle T+1+k; its eValid is in cycle T+1+k+RDLAT.
- Total beats B = (ColEnd−ColBegin+1)×RowNum. The last eValid is in cycle T+B+RDLAT.
- eFinish sampled high in cycle F (DRAIN, pipeline empty) → done in F+1, IDLE and instReady=1 in F+2.
- Degenerate instruction: done in T+2, no eRdEn/eValid at any time.
- Reset asserted mid-operation: all outputs return to reset values asynchronously. No residual eValid after rst_n rises; the instruction is lost.
- No back-to-back overlap: the next instruction cannot be accepted before the cycle after done.

## Test plan
- MaxReduce, ColBegin=2, ColEnd=3, RowNum=2, EBase=0x10, RDLAT=1 → eRdAddr 0x10,0x11,0x12,0x13 in 4 consecutive cycles, gRdEn=0. eValid 4 cycles delayed by 1, eFirst on beat 0, eLast on beats 1 and 3. eFinish after that → done one pulse.
- ExpProd, same range, RDLAT=2 → gRdEn=1 with gRdAddr 2,2,3,3. eValid lags the reads by exactly 2 cycles. eImm/colBegin/colEnd stable throughout.
- EBase=0x3FE, RowNum=4, single column → eRdAddr 0x3FE,0x3FF,0x000,0x001. ColBegin=ColEnd=0xFF, RowNum=1 → exactly 1 beat, no hang.
- Degenerate RowNum=0, and separately ColEnd<ColBegin → no reads, no eValid, done at T+2. eFinish pulsed during ISSUE of a normal instruction → ignored, retire only on the later eFinish.
- instValid held high while busy → instReady=0, no second latch. The second instruction is accepted the cycle instReady returns, with its fields (not the old ones) on the outputs.
- rst_n low during ISSUE beat 2 of 8 → eRdEn/gRdEn/eValid/busy drop immediately. After release, instReady=1 and no stray eValid. A new instruction then runs normally.
